// File: rtl/pc_select_reg.sv
// pc_select_reg: architectural PC register at the head of fetch.
// Each cycle the next PC comes from one of three places: the sequential
// increment, the highest-priority redirect source (index 0 wins), or a
// single buffered redirect that was captured while fetch was stalled.
// A redirect that is accepted raises flush for exactly one cycle. A
// misaligned winner is dropped and reported through misalign/misalign_addr.
module pc_select_reg #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       N_SRC      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       ALIGN_BITS = 2,
  localparam int unsigned      SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [N_SRC-1:0]        req_valid,
  input  logic [N_SRC*ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0]       pc,
  output logic                    flush,
  output logic [SRC_W-1:0]        src_idx,
  output logic                    pend_valid,
  output logic                    misalign,
  output logic [ADDR_W-1:0]       misalign_addr
);

  // Low bits that must be clear on a redirect target; all-zero mask
  // turns the alignment check off.
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    (ALIGN_BITS == 0) ? {ADDR_W{1'b0}} : ~({ADDR_W{1'b1}} << ALIGN_BITS);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  // Index of the lowest set request bit (index 0 has highest priority).
  // Returns 0 when nothing is requested; callers qualify with |valid.
  function automatic logic [SRC_W-1:0] lowest_req(input logic [N_SRC-1:0] valid);
    logic [SRC_W-1:0] idx;
    idx = {SRC_W{1'b0}};
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (valid[i]) begin
        idx = SRC_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Extract the target address belonging to source idx from the flat bus.
  function automatic logic [ADDR_W-1:0] pick_addr(
    input logic [N_SRC*ADDR_W-1:0] bus,
    input logic [SRC_W-1:0]        idx
  );
    logic [ADDR_W-1:0] sel;
    sel = {ADDR_W{1'b0}};
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (idx == SRC_W'(i)) begin
        sel = bus[i*ADDR_W +: ADDR_W];
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // True when any of the alignment-checked low bits is set.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

  // Architectural state
  logic [ADDR_W-1:0] pc_q,            pc_d;
  logic              flush_q,         flush_d;
  logic [SRC_W-1:0]  src_idx_q,       src_idx_d;
  logic              pend_valid_q,    pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q,     pend_addr_d;
  logic              misalign_q,      misalign_d;
  logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;

  // Arbitration results for the current cycle
  logic              win_found_s;
  logic [SRC_W-1:0]  win_idx_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic              win_bad_s;
  logic              win_good_s;

  assign win_found_s = |req_valid;
  assign win_idx_s   = lowest_req(req_valid);
  assign win_addr_s  = pick_addr(req_addr, win_idx_s);
  assign win_bad_s   = win_found_s & is_misaligned(win_addr_s);
  assign win_good_s  = win_found_s & ~win_bad_s;

  // Next-state selection: accepted redirect, then pending release,
  // then sequential increment; stall freezes PC and pending state.
  always_comb begin
    pc_d            = pc_q;
    flush_d         = 1'b0;
    src_idx_d       = src_idx_q;
    pend_valid_d    = pend_valid_q;
    pend_addr_d     = pend_addr_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;

    if (win_bad_s) begin
      misalign_d      = 1'b1;
      misalign_addr_d = win_addr_s;
    end else begin
      misalign_d      = 1'b0;
    end

    if (win_good_s) begin
      flush_d   = 1'b1;
      src_idx_d = win_idx_s;
      if (stall) begin
        // Capture (or replace) the buffered redirect; PC waits.
        pend_addr_d  = win_addr_s;
        pend_valid_d = 1'b1;
      end else begin
        // Live redirect supersedes anything still buffered.
        pc_d         = win_addr_s;
        pend_valid_d = 1'b0;
      end
    end else if (!stall) begin
      if (pend_valid_q) begin
        // Flush already went out when this redirect was captured.
        pc_d         = pend_addr_q;
        pend_valid_d = 1'b0;
      end else begin
        pc_d         = pc_q + STEP_V;
      end
    end else begin
      pc_d         = pc_q;
      pend_valid_d = pend_valid_q;
    end
  end

  // State registers with asynchronous reset to the boot PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      flush_q         <= 1'b0;
      src_idx_q       <= {SRC_W{1'b0}};
      pend_valid_q    <= 1'b0;
      pend_addr_q     <= {ADDR_W{1'b0}};
      misalign_q      <= 1'b0;
      misalign_addr_q <= {ADDR_W{1'b0}};
    end else begin
      pc_q            <= pc_d;
      flush_q         <= flush_d;
      src_idx_q       <= src_idx_d;
      pend_valid_q    <= pend_valid_d;
      pend_addr_q     <= pend_addr_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign pc            = pc_q;
  assign flush         = flush_q;
  assign src_idx       = src_idx_q;
  assign pend_valid    = pend_valid_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_select_reg.sv
// Randomised and directed bench for pc_select_reg, compared against a
// cycle-level reference model of the redirect/stall/pending rules.
module tb_pc_select_reg;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic [3:0]    req_valid;
  logic [127:0]  req_addr;
  logic [31:0]   pc;
  logic          flush;
  logic [1:0]    src_idx;
  logic          pend_valid;
  logic          misalign;
  logic [31:0]   misalign_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_flush;
  logic [1:0]  m_src;
  logic        m_pv;
  logic [31:0] m_pa;
  logic        m_mis;
  logic [31:0] m_misaddr;

  pc_select_reg #(
    .ADDR_W    (32),
    .N_SRC     (4),
    .RESET_PC  (RPC),
    .STEP      (4),
    .ALIGN_BITS(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .pc           (pc),
    .flush        (flush),
    .src_idx      (src_idx),
    .pend_valid   (pend_valid),
    .misalign     (misalign),
    .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_flush = 1'b0; m_src = 2'd0; m_pv = 1'b0;
    m_pa = 32'd0; m_mis = 1'b0; m_misaddr = 32'd0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_step(input logic s, input logic [3:0] rv,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input logic [31:0] a3);
    logic [31:0] a [4];
    int w;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    w = -1;
    for (int i = 0; i < 4; i++) begin
      if (rv[i] && w < 0) w = i;
    end
    m_flush = 1'b0;
    m_mis   = 1'b0;
    if (w >= 0 && (a[w] % 4) != 0) begin
      m_mis     = 1'b1;
      m_misaddr = a[w];
      w         = -1;
    end
    if (w >= 0) begin
      m_flush = 1'b1;
      m_src   = 2'(w);
      if (s) begin
        m_pa = a[w];
        m_pv = 1'b1;
      end else begin
        m_pc = a[w];
        m_pv = 1'b0;
      end
    end else if (!s) begin
      if (m_pv) begin
        m_pc = m_pa;
        m_pv = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},            64'(pc),            64'(m_pc));
    check_eq({tag, ".flush"},         64'(flush),         64'(m_flush));
    check_eq({tag, ".src_idx"},       64'(src_idx),       64'(m_src));
    check_eq({tag, ".pend_valid"},    64'(pend_valid),    64'(m_pv));
    check_eq({tag, ".misalign"},      64'(misalign),      64'(m_mis));
    check_eq({tag, ".misalign_addr"}, 64'(misalign_addr), 64'(m_misaddr));
  endtask

  task automatic drive_cycle(input string tag, input logic s, input logic [3:0] rv,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3);
    stall     = s;
    req_valid = rv;
    req_addr  = {a3, a2, a1, a0};
    model_step(s, rv, a0, a1, a2, a3);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 4) == 0) begin
      r[0] = 1'b1;
    end else begin
      r[1:0] = 2'b00;
    end
    return r;
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; req_valid = 4'd0; req_addr = 128'd0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch from the boot PC
    drive_cycle("seq1", 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    drive_cycle("seq2", 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    drive_cycle("seq3", 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    check_eq("seq_pc_abs", 64'(pc), 64'h10C);

    // Two simultaneous requests: source 1 beats source 2
    drive_cycle("redir", 1'b0, 4'b0110, 32'd0, 32'h200, 32'h300, 32'd0);
    check_eq("redir_pc_abs",  64'(pc),      64'h200);
    check_eq("redir_src_abs", 64'(src_idx), 64'd1);
    check_eq("redir_fl_abs",  64'(flush),   64'd1);
    drive_cycle("after_redir", 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    check_eq("after_redir_pc_abs", 64'(pc), 64'h204);

    // Redirect captured during stall, released later without a second flush
    drive_cycle("cap", 1'b1, 4'b0001, 32'h400, 32'd0, 32'd0, 32'd0);
    check_eq("cap_pv_abs", 64'(pend_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle("hold", 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    end
    drive_cycle("release", 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    check_eq("release_pc_abs", 64'(pc), 64'h400);

    // Live redirect on stall release overrides the buffered one
    drive_cycle("cap2", 1'b1, 4'b0001, 32'h400, 32'd0, 32'd0, 32'd0);
    drive_cycle("override", 1'b0, 4'b1000, 32'd0, 32'd0, 32'd0, 32'h500);
    check_eq("override_pc_abs",  64'(pc),      64'h500);
    check_eq("override_src_abs", 64'(src_idx), 64'd3);
    drive_cycle("post_override", 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);

    // Misaligned winner is dropped; lower-priority good request is ignored
    drive_cycle("misal", 1'b0, 4'b0011, 32'h202, 32'h600, 32'd0, 32'd0);
    check_eq("misal_addr_abs", 64'(misalign_addr), 64'h202);
    drive_cycle("misal_end", 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);

    // PC wrap at the top of the address space
    drive_cycle("to_top", 1'b0, 4'b0001, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0);
    drive_cycle("wrap", 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    check_eq("wrap_pc_abs", 64'(pc), 64'h0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      logic       s;
      logic [3:0] rv;
      s  = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      drive_cycle("rand", s, rv, rand_addr(), rand_addr(), rand_addr(), rand_addr());
    end

    // Asynchronous reset while stalled with a pending redirect
    drive_cycle("pre_rst_cap", 1'b1, 4'b0001, 32'h400, 32'd0, 32'd0, 32'd0);
    drive_cycle("pre_rst_hold", 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    check_eq("pre_rst_pv_abs", 64'(pend_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check_eq("async_rst_pc_abs", 64'(pc), 64'(RPC));
    @(negedge clk);
    rst = 1'b0;
    drive_cycle("post_rst", 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
    check_eq("post_rst_pc_abs", 64'(pc), 64'h104);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_select_reg.md
Name: pc_select_reg

Overview:
- Parametrised successor to the single-bit next-PC select.
- Holds the architectural PC register and picks the next PC each cycle from: sequential increment, N prioritised redirect sources, or one buffered (pending) redirect.
- Adds stall handling, a one-deep pending-redirect buffer, a registered flush pulse and alignment checking.
- Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
- ADDR_W, 32, PC / redirect address width in bits.
- N_SRC, 4, number of redirect sources; index 0 has highest priority.
- RESET_PC, 0, PC value loaded on reset.
- STEP, 4, sequential increment added to PC.
- ALIGN_BITS, 2, low address bits that must be zero on a redirect; 0 disables the check.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC this cycle.
- req_valid  in  N_SRC  per-source redirect request.
- req_addr  in  N_SRC*ADDR_W  source i target at bits [i*ADDR_W +: ADDR_W].
- pc  out  ADDR_W  current PC, registered.
- flush  out  1  one-cycle pulse: a redirect was accepted on the previous edge.
- src_idx  out  max(1,clog2(N_SRC))  index of the last accepted source, registered.
- pend_valid  out  1  a buffered redirect is waiting for stall release.
- misalign  out  1  one-cycle pulse: the winning request was misaligned and dropped.
- misalign_addr  out  ADDR_W  address of the last dropped request.

Behaviour:
- Reset (asynchronous assert, any time including mid-stall):
  - pc=RESET_PC.
  - flush=0, src_idx=0, pend_valid=0, pend_addr=0, misalign=0, misalign_addr=0.
- Arbitration (combinational):
  - Winner w = lowest i with req_valid[i]=1. Only w is considered; all other requests that cycle are discarded.
  - Bad = ALIGN_BITS>0 and req_addr[w][ALIGN_BITS-1:0]!=0.
- Per rising edge, evaluated in this priority order:
  1. Winner exists and bad:
     - Request dropped; pc and pend state follow rules 3–5 as if no request was present.
     - misalign<=1, misalign_addr<=req_addr[w], flush<=0.
  2. Winner exists, good:
     - stall=0: pc<=req_addr[w]; pend_valid<=0 (any pending redirect is discarded, the new one wins).
     - stall=1: pc held; pend_addr<=req_addr[w]; pend_valid<=1 (overwrites any older pending).
     - In both cases: flush<=1, src_idx<=w.
  3. No good winner, stall=0, pend_valid=1:
     - pc<=pend_addr, pend_valid<=0, flush<=0 (flush was already issued at capture).
  4. No good winner, stall=0, pend_valid=0:
     - pc<=pc+STEP, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  5. No good winner, stall=1: pc and pending state hold.
- Pulse outputs:
  - flush and misalign default to 0 on every edge unless set above; they are exactly one cycle wide per event.
  - Back-to-back accepted redirects give flush high on consecutive cycles.
- src_idx holds its value until the next accepted redirect.
- Latency: one edge from accepted request to new pc (unstalled) or to pend_valid (stalled).
- Redirect addresses are not incremented on load; the next sequential step happens on the following unstalled edge.
- N_SRC=1: src_idx is 1 bit and constant 0.

Test Plan:
- Reset then 3 unstalled cycles, RESET_PC=0x100 -> pc 0x100, 0x104, 0x108, 0x10C; flush=0 throughout.
- pc=0x10C; req_valid=4'b0110, addr1=0x200, addr2=0x300; stall=0 for one cycle -> next pc=0x200, src_idx=1, flush=1 for one cycle, then pc=0x204.
- stall=1 while req0 to 0x400 for one cycle, stall held 3 more cycles -> pc unchanged, pend_valid=1, flush one-cycle pulse. On release: pc=0x400, pend_valid=0, no second flush.
- pend_valid=1 to 0x400, stall=0 and req3 to 0x500 on the same cycle -> pc=0x500, src_idx=3, pend_valid=0, flush=1.
- Req0 to 0x202 (ALIGN_BITS=2) -> pc continues sequential, misalign=1 for one cycle, misalign_addr=0x202, flush=0.
- pc=0xFFFFFFFC, no requests -> next pc=0x00000000. Assert rst mid-stall with pend_valid=1 -> pc=RESET_PC and all outputs at reset values immediately, without waiting for a clock edge.
